sys_uio_decoder: RTL and testbench

- Decodes the synchronised HPS user-I/O word stream inside sys_top: command byte first, then data words.
- Generates the io_strobe/io_ack handshake toward the HPS and drives io_dout/io_wide for readback.
- Holds the system config word (cfg, cfg_ready) and a bank of HPS-written status words.
- Sits directly downstream of the gp_out double-register stage; replaces the inline cfg parser.

---
 rtl/sys_uio_decoder_if.sv | 22 ++
 rtl/sys_uio_decoder.sv | 143 ++++++++++++++
 tb/tb_sys_uio_decoder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sys_uio_decoder_if.sv
// HPS user-I/O word stream bundle between the gp_out sync stage and sys_uio_decoder.
// master = HPS side (drives transfer toggle, frame, data, stall); slave = decoder.
interface sys_uio_decoder_if;
    logic        io_clk;
    logic        io_uio;
    logic [15:0] io_din;
    logic        io_wait;
    logic        io_strobe;
    logic        io_ack;
    logic [15:0] io_dout;
    logic        io_wide;

    modport master (
        output io_clk, io_uio, io_din, io_wait,
        input  io_strobe, io_ack, io_dout, io_wide
    );

    modport slave (
        input  io_clk, io_uio, io_din, io_wait,
        output io_strobe, io_ack, io_dout, io_wide
    );
endinterface

// File: rtl/sys_uio_decoder.sv
// HPS user-I/O command decoder: handshake, cfg word, status bank and readback.
// Optional macro SYS_UIO_CHECKSUM_EN adds an XOR checksum of cmd 0x02 words, read by cmd 0x05.
module sys_uio_decoder #(
    parameter int          STATUS_WORDS = 4,
    parameter logic [15:0] CORE_ID      = 16'h00A4
) (
    input  logic                        clk_sys,
    input  logic                        reset_n,
    sys_uio_decoder_if.slave            uio,
    output logic [15:0]                 cfg,
    output logic                        cfg_ready,
    output logic [16*STATUS_WORDS-1:0]  status,
    output logic                        status_set
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;

    logic        rack_q, rack_d;
    logic        ack_q, ack_d;
    logic        old_strobe_q;
    logic [0:0]  state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [4:0]  idx_q, idx_d;
    logic [15:0] dout_q, dout_d;
    logic [15:0] cfg_q, cfg_d;
    logic        cfg_ready_q, cfg_ready_d;
    logic        status_set_q, status_set_d;
    logic [STATUS_WORDS-1:0][15:0] status_q, status_d;
    logic [15:0] csum_q, csum_d;

    logic        strobe;
    logic        xfer;
    logic        idx_valid;
    logic [15:0] rd_word;

    assign strobe        = ~rack_q & uio.io_clk;
    assign xfer          = strobe & ~old_strobe_q;
    assign idx_valid     = int'(idx_q) < STATUS_WORDS;
    assign uio.io_strobe = strobe;
    assign uio.io_ack    = ack_q;
    assign uio.io_dout   = dout_q;
    assign uio.io_wide   = 1'b1;
    assign cfg           = cfg_q;
    assign cfg_ready     = cfg_ready_q;
    assign status        = status_q;
    assign status_set    = status_set_q;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < STATUS_WORDS; i++) begin
            if (idx_q == 5'(i)) rd_word = status_q[i];
        end
    end

    // A pending strobe always advances the handshake so a stall can never swallow a word.
    always_comb begin
        rack_d = rack_q;
        ack_d  = ack_q;
        if (~uio.io_wait | strobe) begin
            rack_d = uio.io_clk;
            ack_d  = rack_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        idx_d        = idx_q;
        dout_d       = dout_q;
        cfg_d        = cfg_q;
        cfg_ready_d  = cfg_ready_q;
        status_d     = status_q;
        status_set_d = 1'b0;
        csum_d       = csum_q;
        if (!uio.io_uio) begin
            // Frame close wins over a coincident data word.
            state_d      = ST_IDLE;
            idx_d        = '0;
            status_set_d = (state_q == ST_DATA) && (cmd_q == 8'h02);
        end else if (xfer) begin
            if (state_q == ST_IDLE) begin
                cmd_d   = uio.io_din[7:0];
                idx_d   = '0;
                state_d = ST_DATA;
                if (uio.io_din[7:0] == 8'h02) csum_d = '0;
            end else begin
                case (cmd_q)
                    8'h01: begin
                        cfg_d       = uio.io_din;
                        cfg_ready_d = 1'b1;
                    end
                    8'h02: begin
                        for (int i = 0; i < STATUS_WORDS; i++) begin
                            if (idx_q == 5'(i)) status_d[i] = uio.io_din;
                        end
                        csum_d = csum_q ^ uio.io_din;
                    end
                    8'h03:   dout_d = idx_valid ? rd_word : 16'h0000;
                    8'h04:   dout_d = CORE_ID;
`ifdef SYS_UIO_CHECKSUM_EN
                    8'h05:   dout_d = csum_q;
`endif
                    default: dout_d = 16'h0000;
                endcase
                idx_d = (idx_q == 5'd31) ? idx_q : idx_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rack_q       <= 1'b0;
            ack_q        <= 1'b0;
            old_strobe_q <= 1'b0;
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            idx_q        <= '0;
            dout_q       <= '0;
            cfg_q        <= '0;
            cfg_ready_q  <= 1'b0;
            status_q     <= '0;
            status_set_q <= 1'b0;
            csum_q       <= '0;
        end else begin
            rack_q       <= rack_d;
            ack_q        <= ack_d;
            old_strobe_q <= strobe;
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            idx_q        <= idx_d;
            dout_q       <= dout_d;
            cfg_q        <= cfg_d;
            cfg_ready_q  <= cfg_ready_d;
            status_q     <= status_d;
            status_set_q <= status_set_d;
`ifdef SYS_UIO_CHECKSUM_EN
            csum_q       <= csum_d;
`else
            csum_q       <= '0;
`endif
        end
    end
endmodule

// File: tb/tb_sys_uio_decoder.sv
// Directed, table-driven bench for sys_uio_decoder (STATUS_WORDS=4, CORE_ID=0x00A4).
module tb_sys_uio_decoder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cfg;
    logic        cfg_ready;
    logic [63:0] status;
    logic        status_set;

    sys_uio_decoder_if dif ();

    sys_uio_decoder #(.STATUS_WORDS(4), .CORE_ID(16'h00A4)) dut (
        .clk_sys    (clk),
        .reset_n    (reset_n),
        .uio        (dif),
        .cfg        (cfg),
        .cfg_ready  (cfg_ready),
        .status     (status),
        .status_set (status_set)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       cmd;
        logic [2:0]       n;
        logic [5:0][15:0] d;
        logic [5:0][15:0] dout;
        logic [15:0]      cfg;
        logic             rdy;
        logic [63:0]      status;
        logic [1:0]       pulses;
    } frame_t;

    frame_t vec [9];
    int n_cmp = 0;
    int n_bad = 0;
    int ev_cnt = 0;
    int pulse_cnt = 0;

    always @(posedge dif.io_strobe) ev_cnt++;
    always @(negedge clk) if (status_set === 1'b1) pulse_cnt++;

    function automatic logic [5:0][15:0] w6(input logic [15:0] a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Waits (bounded) for io_ack to reach lvl; pre_dout is io_dout one cycle before it does.
    task automatic wait_ack(input logic lvl, output int lat, output logic [15:0] pre_dout);
        lat = -1;
        pre_dout = dif.io_dout;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (dif.io_ack === lvl) begin
                lat = k;
                break;
            end
            pre_dout = dif.io_dout;
        end
    endtask

    task automatic send_word(input logic [15:0] din, input logic [15:0] exp_dout, input logic chk_dout);
        int lat;
        logic [15:0] pre;
        dif.io_din = din;
        dif.io_clk = 1'b1;
        wait_ack(1'b1, lat, pre);
        chk("ack_rise_lat", 64'(lat), 64'd2);
        if (chk_dout) chk("dout_before_ack", 64'(pre), 64'(exp_dout));
        $display("xfer din=%h dout=%h ack_lat=%0d", din, pre, lat);
        dif.io_clk = 1'b0;
        wait_ack(1'b0, lat, pre);
        chk("ack_fall_lat", 64'(lat), 64'd2);
    endtask

    task automatic run_frame(input frame_t f);
        int ev0, p0;
        ev0 = ev_cnt;
        p0  = pulse_cnt;
        dif.io_uio = 1'b1;
        send_word({8'h00, f.cmd}, 16'h0000, 1'b0);
        for (int w = 0; w < int'(f.n); w++) send_word(f.d[w], f.dout[w], 1'b1);
        dif.io_uio = 1'b0;
        repeat (3) @(negedge clk);
        chk("cfg", 64'(cfg), 64'(f.cfg));
        chk("cfg_ready", 64'(cfg_ready), 64'(f.rdy));
        chk("status", status, f.status);
        chk("status_set_pulses", 64'(pulse_cnt - p0), 64'(f.pulses));
        chk("xfer_events", 64'(ev_cnt - ev0), 64'(int'(f.n) + 1));
        $display("frame cmd=%h words=%0d cfg=%h status=%h", f.cmd, f.n, cfg, status);
    endtask

    initial begin
        int ev0, p0, lat, hi_ack, hi_strobe;
        logic [15:0] pre;
        logic [15:0] ck_exp;
`ifdef SYS_UIO_CHECKSUM_EN
        ck_exp = 16'h0FF0;
`else
        ck_exp = 16'h0000;
`endif
        vec[0] = '{8'h01, 3'd1, w6(16'h0064, 0, 0, 0, 0, 0), w6(0, 0, 0, 0, 0, 0),
                   16'h0064, 1'b1, 64'h0, 2'd0};
        vec[1] = '{8'h02, 3'd5, w6(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 0),
                   w6(0, 0, 0, 0, 0, 0), 16'h0064, 1'b1, 64'h4444_3333_2222_1111, 2'd1};
        vec[2] = '{8'h03, 3'd3, w6(0, 0, 0, 0, 0, 0), w6(16'h1111, 16'h2222, 16'h3333, 0, 0, 0),
                   16'h0064, 1'b1, 64'h4444_3333_2222_1111, 2'd0};
        vec[3] = '{8'h04, 3'd2, w6(0, 0, 0, 0, 0, 0), w6(16'h00A4, 16'h00A4, 0, 0, 0, 0),
                   16'h0064, 1'b1, 64'h4444_3333_2222_1111, 2'd0};
        vec[4] = '{8'h03, 3'd6, w6(0, 0, 0, 0, 0, 0),
                   w6(16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 0),
                   16'h0064, 1'b1, 64'h4444_3333_2222_1111, 2'd0};
        vec[5] = '{8'h07, 3'd1, w6(16'hFFFF, 0, 0, 0, 0, 0), w6(0, 0, 0, 0, 0, 0),
                   16'h0064, 1'b1, 64'h4444_3333_2222_1111, 2'd0};
        vec[6] = '{8'h01, 3'd2, w6(16'h1234, 16'hBEEF, 0, 0, 0, 0), w6(0, 0, 0, 0, 0, 0),
                   16'hBEEF, 1'b1, 64'h4444_3333_2222_1111, 2'd0};
        vec[7] = '{8'h02, 3'd2, w6(16'h00FF, 16'h0F0F, 0, 0, 0, 0), w6(0, 0, 0, 0, 0, 0),
                   16'h0000, 1'b0, 64'h0000_0000_0F0F_00FF, 2'd1};
        vec[8] = '{8'h05, 3'd1, w6(0, 0, 0, 0, 0, 0), w6(ck_exp, 0, 0, 0, 0, 0),
                   16'h0000, 1'b0, 64'h0000_0000_0F0F_00FF, 2'd0};

        reset_n     = 1'b0;
        dif.io_clk  = 1'b0;
        dif.io_uio  = 1'b0;
        dif.io_din  = 16'h0000;
        dif.io_wait = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ack", 64'(dif.io_ack), 64'd0);
        chk("rst_dout", 64'(dif.io_dout), 64'd0);
        chk("rst_cfg", 64'(cfg), 64'd0);
        chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        chk("rst_status", status, 64'd0);
        chk("rst_status_set", 64'(status_set), 64'd0);
        chk("io_wide", 64'(dif.io_wide), 64'd1);
        chk("rst_strobe", 64'(dif.io_strobe), 64'd0);

        for (int i = 0; i <= 6; i++) run_frame(vec[i]);

        // Stall: strobe consumed while io_wait is high, ack must freeze until release.
        ev0 = ev_cnt;
        hi_ack = 0;
        hi_strobe = 0;
        dif.io_din  = 16'h0001;
        dif.io_wait = 1'b1;
        dif.io_clk  = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (dif.io_ack !== 1'b0) hi_ack++;
            if (dif.io_strobe !== 1'b0) hi_strobe++;
        end
        chk("wait_ack_frozen", 64'(hi_ack), 64'd0);
        chk("wait_strobe_consumed", 64'(hi_strobe), 64'd0);
        dif.io_wait = 1'b0;
        wait_ack(1'b1, lat, pre);
        chk("wait_release_lat", 64'(lat), 64'd1);
        dif.io_clk = 1'b0;
        wait_ack(1'b0, lat, pre);
        chk("wait_ack_fall_lat", 64'(lat), 64'd2);
        chk("wait_one_event", 64'(ev_cnt - ev0), 64'd1);
        chk("idle_xfer_ignored_cfg", 64'(cfg), 64'hBEEF);
        chk("idle_xfer_ignored_dout", 64'(dif.io_dout), 64'd0);
        $display("stall transfer: events=%0d", ev_cnt - ev0);

        // Reset in the middle of a cmd 0x02 frame.
        p0 = pulse_cnt;
        dif.io_uio = 1'b1;
        send_word(16'h0002, 16'h0000, 1'b0);
        send_word(16'hAAAA, 16'h0000, 1'b0);
        send_word(16'hBBBB, 16'h0000, 1'b0);
        chk("midframe_status_written", status, 64'h4444_3333_BBBB_AAAA);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_status", status, 64'd0);
        chk("midrst_cfg", 64'(cfg), 64'd0);
        chk("midrst_cfg_ready", 64'(cfg_ready), 64'd0);
        reset_n    = 1'b1;
        dif.io_uio = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_no_pulse", 64'(pulse_cnt - p0), 64'd0);
        $display("reset mid-frame: status=%h cfg=%h", status, cfg);

        for (int i = 7; i <= 8; i++) run_frame(vec[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
